accum_datapath: RTL and testbench
=================================

ACCUM_DATAPATH -- requirements
Module: accum_datapath

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the sample, accumulator and SUM width in bits.
REQ-002 Parameter PRESCALE, default 16, SHALL set the startup delay in S0 cycles; legal range 2..65536.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 S0..S5  input  1 each  SHALL be the one-hot state strobes from the sequencing FSM.
REQ-006 DIN  input  WIDTH  SHALL be the sample data, captured in S1.
REQ-007 OVERFLOW  output  1  SHALL tell the FSM that the startup delay has elapsed (S0 exit).
REQ-008 CLR  output  1  SHALL tell the FSM that the current sample is zero (S2 branch: skip S3/S4).
REQ-009 SUM  output  WIDTH  SHALL be the registered accumulator value, published in S5.
REQ-010 WRAPS  output  16  SHALL be the saturating count of accumulator carry-outs.
REQ-011 STROBE  output  1  SHALL be a one-cycle pulse marking a SUM update.
REQ-012 ERR  output  1  SHALL be a sticky flag for an illegal strobe combination.

Function
REQ-013 The prescaler PRE (16 bit) SHALL increment on each edge with S0=1 and PRE != PRESCALE-1, and SHALL hold at PRESCALE-1 once there.
REQ-014 OVERFLOW SHALL equal S0 AND (PRE == PRESCALE-1), combinationally from registered PRE, so the FSM leaves S0 exactly PRESCALE cycles after S0 first asserts.
REQ-015 On an edge with S1=1, SAMPLE SHALL load DIN.
REQ-016 CLR SHALL equal S2 AND (SAMPLE == 0), combinationally; CLR SHALL be 0 outside S2.
REQ-017 On an edge with S3=1, ACC SHALL load the low WIDTH bits of ACC+SAMPLE, and CARRY SHALL load the carry-out.
REQ-018 On an edge with S4=1 and CARRY=1, WRAPS SHALL increment, saturating at 16'hFFFF; CARRY SHALL then clear.
REQ-019 On an edge with S5=1, SUM SHALL load ACC, and STROBE SHALL be 1 for exactly the following cycle.
REQ-020 A zero sample (S2 then S5) SHALL leave ACC, CARRY and WRAPS unchanged, and SHALL still produce a STROBE with an unchanged SUM.
REQ-021 Accumulation SHALL wrap modulo 2^WIDTH; for example, with WIDTH=8, 8'hF0 + 8'h20 gives ACC = 8'h10 and CARRY = 1.
REQ-022 Latency SHALL be as follows:
- DIN sampled in S1 appears on SUM after the S5 edge.
- This is 5 edges for a nonzero sample (S1..S5) and 3 edges for a zero sample (S1, S2, S5).
REQ-023 If more than one S input is 1 on an edge, the block SHALL act only on the lowest-numbered asserted strobe and SHALL set ERR.
REQ-024 If no S input is 1, all registers SHALL hold and STROBE SHALL be 0.

Reset
REQ-025 Asserting RESET SHALL immediately force the following to 0, independent of CLK:
- PRE, SAMPLE, ACC, CARRY
- SUM, WRAPS, STROBE, ERR
REQ-026 RESET asserted mid-sequence (any Sx) SHALL abort it: no partial ACC update and no STROBE after release.
REQ-027 While RESET=1, OVERFLOW and CLR SHALL be 0 regardless of the S inputs.
REQ-028 After RESET deasserts, the first rising edge SHALL be the first functional edge; no extra synchronisation cycle.

Verification
REQ-029 PRESCALE=4, hold S0=1 after reset -> OVERFLOW=0 for 3 cycles, then 1 on the 4th cycle.
REQ-030 DIN=8'h05 through S1-S2-S3-S4-S5 from ACC=0 -> CLR=0 in S2; SUM=8'h05 and STROBE=1 the cycle after S5; WRAPS=0.
REQ-031 ACC=8'hF0, DIN=8'h20, full sequence -> SUM=8'h10, WRAPS=1.
REQ-032 DIN=0 through S1-S2-S5 -> CLR=1 during S2; SUM unchanged; one STROBE pulse.
REQ-033 S3 and S4 both 1 on one edge -> only the S3 add occurs; ERR=1 and stays 1 until RESET.
REQ-034 RESET pulsed asynchronously during S3 (between edges) -> ACC=0 and SUM=0 at once; no STROBE after release.

Source files
------------

// File: rtl/accum_datapath.sv
// Datapath slave of the sampling/accumulation FSM: startup prescaler, sample
// capture, modulo accumulator with carry-out counter, and published SUM.
module accum_datapath #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             S0,
   input  logic             S1,
   input  logic             S2,
   input  logic             S3,
   input  logic             S4,
   input  logic             S5,
   input  logic [WIDTH-1:0] DIN,
   output logic             OVERFLOW,
   output logic             CLR,
   output logic [WIDTH-1:0] SUM,
   output logic [15:0]      WRAPS,
   output logic             STROBE,
   output logic             ERR
);

   localparam logic [15:0] pre_max = 16'(PRESCALE - 1);

   logic [15:0]      pre;
   logic [WIDTH-1:0] sample;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [5:0]       s_raw;
   logic [5:0]       s_act;
   logic             multi;
   logic [WIDTH:0]   add_res;

   assign s_raw = {S5, S4, S3, S2, S1, S0};

   // Only the lowest-numbered asserted strobe is acted on; any extra strobe is an error.
   always_comb begin
      s_act = 6'b000000;
      if (s_raw[0])      s_act[0] = 1'b1;
      else if (s_raw[1]) s_act[1] = 1'b1;
      else if (s_raw[2]) s_act[2] = 1'b1;
      else if (s_raw[3]) s_act[3] = 1'b1;
      else if (s_raw[4]) s_act[4] = 1'b1;
      else if (s_raw[5]) s_act[5] = 1'b1;
   end

   assign multi   = (s_raw & (s_raw - 6'd1)) != 6'd0;
   assign add_res = {1'b0, acc} + {1'b0, sample};

   // Status to the FSM is gated by RESET so it never sees a stale request.
   assign OVERFLOW = S0 && (pre == pre_max) && !RESET;
   assign CLR      = S2 && (sample == '0) && !RESET;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pre    <= '0;
         sample <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         SUM    <= '0;
         WRAPS  <= '0;
         STROBE <= 1'b0;
         ERR    <= 1'b0;
      end else begin
         STROBE <= s_act[5];
         if (multi) ERR <= 1'b1;
         if (s_act[0] && (pre != pre_max)) pre <= pre + 16'd1;
         if (s_act[1]) sample <= DIN;
         if (s_act[3]) begin
            acc   <= add_res[WIDTH-1:0];
            carry <= add_res[WIDTH];
         end
         if (s_act[4] && carry) begin
            if (WRAPS != 16'hFFFF) WRAPS <= WRAPS + 16'd1;
            carry <= 1'b0;
         end
         if (s_act[5]) SUM <= acc;
      end
   end

endmodule

// File: tb/tb_accum_datapath.sv
// Bench for accum_datapath: table-driven sample sequences plus hand-written
// prescaler, error-priority and asynchronous-reset sequences.
module tb_accum_datapath;

   localparam int W = 8;

   logic         CLK;
   logic         RESET;
   logic [5:0]   s_vec;
   logic [W-1:0] din;
   logic         OVERFLOW, CLR, STROBE, ERR;
   logic [W-1:0] SUM;
   logic [15:0]  WRAPS;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic clr_seen, ovf_seen;

   localparam logic [5:0] ST_IDLE = 6'b000000;
   localparam logic [5:0] ST_S0   = 6'b000001;
   localparam logic [5:0] ST_S1   = 6'b000010;
   localparam logic [5:0] ST_S2   = 6'b000100;
   localparam logic [5:0] ST_S3   = 6'b001000;
   localparam logic [5:0] ST_S4   = 6'b010000;
   localparam logic [5:0] ST_S5   = 6'b100000;

   typedef struct {
      logic [W-1:0] din;
      logic         clr;
      logic [W-1:0] sum;
      logic [15:0]  wraps;
   } vec_t;

   vec_t vecs[8];

   accum_datapath #(.WIDTH(W), .PRESCALE(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .S0(s_vec[0]), .S1(s_vec[1]), .S2(s_vec[2]),
      .S3(s_vec[3]), .S4(s_vec[4]), .S5(s_vec[5]),
      .DIN(din), .OVERFLOW(OVERFLOW), .CLR(CLR), .SUM(SUM),
      .WRAPS(WRAPS), .STROBE(STROBE), .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one strobe cycle; sample combinational status before the edge.
   task automatic apply(input logic [5:0] s, input logic [W-1:0] d);
      @(negedge CLK);
      s_vec = s;
      din   = d;
      #1;
      clr_seen = CLR;
      ovf_seen = OVERFLOW;
      @(posedge CLK);
      #1;
   endtask

   task automatic run_sample(input logic [W-1:0] d, input logic [W-1:0] exp_sum,
                             input logic exp_clr, input logic [15:0] exp_wraps);
      apply(ST_S1, d);
      apply(ST_S2, '0);
      chk("clr_in_s2", clr_seen, exp_clr);
      if (d != '0) begin
         apply(ST_S3, '0);
         apply(ST_S4, '0);
      end
      exp_q.push_back(exp_sum);
      apply(ST_S5, '0);
      apply(ST_IDLE, '0);
      chk("wraps", WRAPS, exp_wraps);
   endtask

   // Every STROBE cycle must match a queued SUM; a strobe with nothing queued is an error.
   always @(negedge CLK) begin
      if (!RESET && STROBE) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: act=1 exp=0 sum=%0h at %0t", SUM, $time);
         end else begin
            chk("sum_on_strobe", SUM, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [W-1:0] m_acc;
      logic [15:0]  m_wraps;
      logic [W:0]   m_add;
      logic [W-1:0] r;

      vecs[0] = '{8'h05, 1'b0, 8'h05, 16'd0};
      vecs[1] = '{8'hEB, 1'b0, 8'hF0, 16'd0};
      vecs[2] = '{8'h20, 1'b0, 8'h10, 16'd1};
      vecs[3] = '{8'h00, 1'b1, 8'h10, 16'd1};
      vecs[4] = '{8'hFF, 1'b0, 8'h0F, 16'd2};
      vecs[5] = '{8'h80, 1'b0, 8'h8F, 16'd2};
      vecs[6] = '{8'h80, 1'b0, 8'h0F, 16'd3};
      vecs[7] = '{8'h00, 1'b1, 8'h0F, 16'd3};

      // Reset state, with S0 and S2 asserted to show status is masked.
      RESET = 1'b1;
      s_vec = ST_S0 | ST_S2;
      din   = '0;
      #12;
      chk("rst_overflow", OVERFLOW, 1'b0);
      chk("rst_clr", CLR, 1'b0);
      chk("rst_sum", SUM, 8'h00);
      chk("rst_wraps", WRAPS, 16'h0000);
      chk("rst_strobe", STROBE, 1'b0);
      chk("rst_err", ERR, 1'b0);
      @(negedge CLK);
      s_vec = ST_IDLE;
      RESET = 1'b0;

      // Prescaler of 4: OVERFLOW low three S0 cycles, high on the fourth and held.
      for (int i = 0; i < 6; i++) begin
         apply(ST_S0, '0);
         chk($sformatf("overflow_c%0d", i), ovf_seen, (i >= 3) ? 1'b1 : 1'b0);
      end
      chk("err_after_prescale", ERR, 1'b0);

      for (int i = 0; i < 8; i++)
         run_sample(vecs[i].din, vecs[i].sum, vecs[i].clr, vecs[i].wraps);

      // S3+S4 together: only the add (0F+F5 -> 04 with carry) happens.
      apply(ST_S1, 8'hF5);
      apply(ST_S2, '0);
      chk("clr_nonzero", clr_seen, 1'b0);
      apply(ST_S3 | ST_S4, '0);
      chk("err_set", ERR, 1'b1);
      chk("wraps_no_s4", WRAPS, 16'd3);
      exp_q.push_back(8'h04);
      apply(ST_S5, '0);
      apply(ST_IDLE, '0);
      apply(ST_IDLE, '0);
      chk("err_sticky", ERR, 1'b1);
      chk("wraps_after_err", WRAPS, 16'd3);

      // Random samples against a reference accumulator.
      m_acc   = 8'h04;
      m_wraps = 16'd3;
      for (int i = 0; i < 10; i++) begin
         r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         if (r != 0) begin
            m_add   = {1'b0, m_acc} + {1'b0, r};
            m_acc   = m_add[W-1:0];
            m_wraps = m_wraps + 16'(m_add[W]);
         end
         run_sample(r, m_acc, (r == 0) ? 1'b1 : 1'b0, m_wraps);
      end

      // Asynchronous reset pulse between edges while in S3.
      apply(ST_S1, 8'h30);
      apply(ST_S2, '0);
      @(negedge CLK);
      s_vec = ST_S3;
      #2;
      RESET = 1'b1;
      #1;
      chk("async_sum", SUM, 8'h00);
      chk("async_wraps", WRAPS, 16'h0000);
      chk("async_strobe", STROBE, 1'b0);
      chk("async_err", ERR, 1'b0);
      chk("async_clr", CLR, 1'b0);
      s_vec = ST_IDLE;
      #1;
      RESET = 1'b0;
      for (int i = 0; i < 4; i++) apply(ST_IDLE, '0);
      chk("post_rst_sum", SUM, 8'h00);
      chk("post_rst_err", ERR, 1'b0);

      // ACC restarted from zero.
      run_sample(8'h07, 8'h07, 1'b0, 16'd0);
      apply(ST_IDLE, '0);

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
